// File: rtl/pxs_sched_if.sv
`default_nettype none
// pxs_sched_if: four aligned candidate pixel streams, scheduling controls and the scheduled output.
// Word layout: R[3:0] G[7:4] B[11:8] HS[12] VS[13] Active[14] XC[20:15] YC[25:21].
interface pxs_sched_if;
  logic [25:0] RGBStr0_i;
  logic [25:0] RGBStr1_i;
  logic [25:0] RGBStr2_i;
  logic [25:0] RGBStr3_i;
  logic        auto_i;
  logic [1:0]  sel_i;
  logic        next_i;
  logic [3:0]  mask_i;
  logic [7:0]  dwell_i;
  logic [25:0] RGBStr_o;
  logic [1:0]  sel_o;
  logic        switch_o;

  modport master (
    output RGBStr0_i, RGBStr1_i, RGBStr2_i, RGBStr3_i,
    output auto_i, sel_i, next_i, mask_i, dwell_i,
    input  RGBStr_o, sel_o, switch_o
  );

  modport slave (
    input  RGBStr0_i, RGBStr1_i, RGBStr2_i, RGBStr3_i,
    input  auto_i, sel_i, next_i, mask_i, dwell_i,
    output RGBStr_o, sel_o, switch_o
  );
endinterface
`default_nettype wire

// File: rtl/pxs_stream_scheduler.sv
`default_nettype none
// pxs_stream_scheduler: frame-aligned manual/auto-cycling selector over four pixel streams.
// Build macro PXS_SCHED_BLANK_EN inserts one RGB-blanked frame after every switch.
module pxs_stream_scheduler (
  input  logic       px_clk,
  input  logic       reset,
  pxs_sched_if.slave sched
);
  localparam int unsigned RGB_MSB = 11;
  localparam int unsigned XC_LSB  = 15;
  localparam int unsigned XC_MSB  = 20;
  localparam int unsigned YC_LSB  = 21;
  localparam int unsigned YC_MSB  = 25;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1
`ifdef PXS_SCHED_BLANK_EN
    ,ST_BLANK = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  pend_sel_q, pend_sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        switch_q, switch_d;
  logic [25:0] out_q, out_d;
  logic        origin_q;
  logic        auto_q;

  logic        at_origin;
  logic        sof;
  logic [7:0]  dwell_eff;
  logic        dwell_hit;
  logic [1:0]  adv_sel;
  logic [1:0]  target_sel;

  assign at_origin = (sched.RGBStr0_i[XC_MSB:XC_LSB] == '0) &&
                     (sched.RGBStr0_i[YC_MSB:YC_LSB] == '0);
  assign sof       = at_origin && !origin_q;

  // The frame in progress is frame cnt_q+1, so the request is raised inside the
  // dwell-th frame and the switch lands exactly at its end.
  assign dwell_eff = (sched.dwell_i == 8'd0) ? 8'd1 : sched.dwell_i;
  assign dwell_hit = (cnt_q >= (dwell_eff - 8'd1));

  // Nearest enabled index above sel_q (mod 4); falls back to sel_q when none.
  always_comb begin : p_adv
    logic [1:0] idx;
    adv_sel = sel_q;
    idx     = sel_q;
    for (int k = 3; k >= 1; k--) begin
      idx = sel_q + 2'(k);
      if (sched.mask_i[idx]) adv_sel = idx;
    end
  end

  assign target_sel = sched.auto_i ? adv_sel : sched.sel_i;

  always_comb begin : p_next
    state_d    = state_q;
    sel_d      = sel_q;
    pend_sel_d = pend_sel_q;
    cnt_d      = cnt_q;
    switch_d   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (!sched.auto_i) begin
          cnt_d = 8'd0;
          if (sched.sel_i != sel_q) begin
            pend_sel_d = sched.sel_i;
            state_d    = ST_PEND;
          end
        end else begin
          if (sof) cnt_d = cnt_q + 8'd1;
          if (dwell_hit || sched.next_i) begin
            if (adv_sel != sel_q) begin
              pend_sel_d = adv_sel;
              state_d    = ST_PEND;
            end else begin
              cnt_d = 8'd0;
            end
          end
        end
      end

      ST_PEND: begin
        pend_sel_d = target_sel;
        if (target_sel == sel_q) begin
          state_d = ST_RUN;
        end else if (sof) begin
          sel_d    = pend_sel_q;
          switch_d = 1'b1;
          cnt_d    = 8'd0;
`ifdef PXS_SCHED_BLANK_EN
          state_d  = ST_BLANK;
`else
          state_d  = ST_RUN;
`endif
        end
      end

`ifdef PXS_SCHED_BLANK_EN
      ST_BLANK: begin
        if (sof) state_d = ST_RUN;
      end
`endif

      default: state_d = ST_RUN;
    endcase

    if (sched.auto_i != auto_q) cnt_d = 8'd0;
  end

  // Mux on the next selection so the SOF pixel itself comes from the new stream.
  always_comb begin : p_out
    case (sel_d)
      2'd0:    out_d = sched.RGBStr0_i;
      2'd1:    out_d = sched.RGBStr1_i;
      2'd2:    out_d = sched.RGBStr2_i;
      default: out_d = sched.RGBStr3_i;
    endcase
`ifdef PXS_SCHED_BLANK_EN
    if (state_d == ST_BLANK) out_d[RGB_MSB:0] = '0;
`endif
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      sel_q      <= 2'd0;
      pend_sel_q <= 2'd0;
      cnt_q      <= 8'd0;
      switch_q   <= 1'b0;
      out_q      <= 26'd0;
      origin_q   <= 1'b0;
      auto_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      pend_sel_q <= pend_sel_d;
      cnt_q      <= cnt_d;
      switch_q   <= switch_d;
      out_q      <= out_d;
      origin_q   <= at_origin;
      auto_q     <= sched.auto_i;
    end
  end

  assign sched.RGBStr_o = out_q;
  assign sched.sel_o    = sel_q;
  assign sched.switch_o = switch_q;
endmodule
`default_nettype wire

// File: tb/tb_pxs_stream_scheduler.sv
`default_nettype none
// tb_pxs_stream_scheduler: directed scenarios on an 8x4-pixel frame raster.
module tb_pxs_stream_scheduler;
  localparam int W = 8;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   miss = 0;
  int   cur_x = 3, cur_y = 1;
  int   prev_x = 3, prev_y = 1;

  pxs_sched_if sif ();

  pxs_stream_scheduler dut (
    .px_clk (clk),
    .reset  (rst),
    .sched  (sif)
  );

  always #5 clk = ~clk;

  // Stream n carries RGB nibbles of n+1; sync/coords/Active come from the shared raster.
  function automatic logic [25:0] mk(int n, int x, int y);
    logic [25:0] w;
    w        = '0;
    w[11:0]  = {3{4'(n + 1)}};
    w[12]    = (x == 0);
    w[13]    = (y == 0);
    w[14]    = 1'b1;
    w[20:15] = 6'(x);
    w[25:21] = 5'(y);
    return w;
  endfunction

  task automatic drive();
    sif.RGBStr0_i = mk(0, cur_x, cur_y);
    sif.RGBStr1_i = mk(1, cur_x, cur_y);
    sif.RGBStr2_i = mk(2, cur_x, cur_y);
    sif.RGBStr3_i = mk(3, cur_x, cur_y);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    prev_x = cur_x;
    prev_y = cur_y;
    if (cur_x == W - 1) begin
      cur_x = 0;
      cur_y = (cur_y == H - 1) ? 0 : cur_y + 1;
    end else begin
      cur_x = cur_x + 1;
    end
    drive();
  endtask

  // Advance until the raster sits on pixel (0,0): the SOF cycle.
  task automatic wait_sof();
    int guard = 0;
    while (!(cur_x == 0 && cur_y == 0) && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      vec++; miss++;
      $display("FAIL wait_sof: no SOF within %0d cycles", guard);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive();
    repeat (3) tick();
    vec++; if (sif.RGBStr_o !== 26'd0) begin miss++; $display("FAIL rst_out: got %h want 0", sif.RGBStr_o); end
    vec++; if (sif.sel_o !== 2'd0) begin miss++; $display("FAIL rst_sel: got %0d want 0", sif.sel_o); end
    vec++; if (sif.switch_o !== 1'b0) begin miss++; $display("FAIL rst_sw: got %b want 0", sif.switch_o); end
    rst = 1'b0;
    tick();
    vec++; if (sif.RGBStr_o !== mk(0, prev_x, prev_y)) begin miss++; $display("FAIL first_out: got %h want %h", sif.RGBStr_o, mk(0, prev_x, prev_y)); end
    vec++; if (sif.sel_o !== 2'd0) begin miss++; $display("FAIL first_sel: got %0d want 0", sif.sel_o); end
  endtask

  task automatic test_manual();
    repeat (3) tick();
    sif.sel_i = 2'd2;
    repeat (5) tick();
    vec++; if (sif.sel_o !== 2'd0 || sif.switch_o !== 1'b0) begin miss++; $display("FAIL man_midframe: got sel %0d sw %b want 0 0", sif.sel_o, sif.switch_o); end
    wait_sof();
    vec++; if (sif.sel_o !== 2'd0) begin miss++; $display("FAIL man_presof: got %0d want 0", sif.sel_o); end
    tick();
    vec++; if (sif.sel_o !== 2'd2 || sif.switch_o !== 1'b1) begin miss++; $display("FAIL man_switch: got sel %0d sw %b want 2 1", sif.sel_o, sif.switch_o); end
    vec++; if (sif.RGBStr_o !== mk(2, 0, 0)) begin miss++; $display("FAIL man_out0: got %h want %h", sif.RGBStr_o, mk(2, 0, 0)); end
    tick();
    vec++; if (sif.switch_o !== 1'b0 || sif.RGBStr_o !== mk(2, 1, 0)) begin miss++; $display("FAIL man_out1: got sw %b out %h want 0 %h", sif.switch_o, sif.RGBStr_o, mk(2, 1, 0)); end
  endtask

  task automatic test_sof_coincide();
    wait_sof();
    sif.sel_i = 2'd3;
    tick();
    vec++; if (sif.sel_o !== 2'd2 || sif.switch_o !== 1'b0) begin miss++; $display("FAIL coin_hold: got sel %0d sw %b want 2 0", sif.sel_o, sif.switch_o); end
    wait_sof();
    tick();
    vec++; if (sif.sel_o !== 2'd3 || sif.switch_o !== 1'b1) begin miss++; $display("FAIL coin_switch: got sel %0d sw %b want 3 1", sif.sel_o, sif.switch_o); end
    vec++; if (sif.RGBStr_o !== mk(3, 0, 0)) begin miss++; $display("FAIL coin_out: got %h want %h", sif.RGBStr_o, mk(3, 0, 0)); end
  endtask

  task automatic test_cancel();
    repeat (4) tick();
    sif.sel_i = 2'd1;
    repeat (3) tick();
    sif.sel_i = 2'd3;
    wait_sof();
    tick();
    vec++; if (sif.sel_o !== 2'd3 || sif.switch_o !== 1'b0) begin miss++; $display("FAIL cancel: got sel %0d sw %b want 3 0", sif.sel_o, sif.switch_o); end
    sif.sel_i = 2'd0;
    tick();
    wait_sof();
    tick();
    vec++; if (sif.sel_o !== 2'd0 || sif.switch_o !== 1'b1) begin miss++; $display("FAIL back_to0: got sel %0d sw %b want 0 1", sif.sel_o, sif.switch_o); end
  endtask

  task automatic test_auto();
    logic [1:0] exp_sel [6] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0};
    logic       exp_sw  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    repeat (4) tick();
    sif.mask_i  = 4'b1011;
    sif.dwell_i = 8'd2;
    sif.auto_i  = 1'b1;
    for (int f = 0; f < 6; f++) begin
      wait_sof();
      tick();
      vec++;
      if (sif.sel_o !== exp_sel[f] || sif.switch_o !== exp_sw[f]) begin
        miss++;
        $display("FAIL auto_seq[%0d]: got sel %0d sw %b want %0d %b", f, sif.sel_o, sif.switch_o, exp_sel[f], exp_sw[f]);
      end
    end
  endtask

  task automatic test_dwell_zero();
    logic [1:0] exp_sel [3] = '{2'd1, 2'd3, 2'd0};
    int sw_cnt = 0;
    int off_cnt = 0;
    sif.dwell_i = 8'd0;
    for (int f = 0; f < 3; f++) begin
      wait_sof();
      tick();
      vec++;
      if (sif.sel_o !== exp_sel[f] || sif.switch_o !== 1'b1) begin
        miss++;
        $display("FAIL dwell0[%0d]: got sel %0d sw %b want %0d 1", f, sif.sel_o, sif.switch_o, exp_sel[f]);
      end
    end
    sif.mask_i = 4'b0000;
    for (int i = 0; i < 3 * W * H; i++) begin
      tick();
      if (sif.switch_o === 1'b1) sw_cnt++;
      if (sif.sel_o !== 2'd0) off_cnt++;
    end
    vec++; if (sw_cnt != 0) begin miss++; $display("FAIL mask0_sw: got %0d pulses want 0", sw_cnt); end
    vec++; if (off_cnt != 0) begin miss++; $display("FAIL mask0_sel: got %0d cycles off stream 0 want 0", off_cnt); end
  endtask

  task automatic test_next();
    sif.mask_i  = 4'b1111;
    sif.dwell_i = 8'd10;
    repeat (4) tick();
    sif.next_i = 1'b1;
    tick();
    sif.next_i = 1'b0;
    repeat (3) tick();
    sif.next_i = 1'b1;
    tick();
    sif.next_i = 1'b0;
    vec++; if (sif.sel_o !== 2'd0) begin miss++; $display("FAIL next_early: got %0d want 0", sif.sel_o); end
    wait_sof();
    tick();
    vec++; if (sif.sel_o !== 2'd1 || sif.switch_o !== 1'b1) begin miss++; $display("FAIL next_switch: got sel %0d sw %b want 1 1", sif.sel_o, sif.switch_o); end
    wait_sof();
    tick();
    vec++; if (sif.sel_o !== 2'd1 || sif.switch_o !== 1'b0) begin miss++; $display("FAIL next_extra: got sel %0d sw %b want 1 0", sif.sel_o, sif.switch_o); end
  endtask

  task automatic test_reset_pend();
    sif.auto_i = 1'b0;
    sif.sel_i  = 2'd2;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    vec++; if (sif.sel_o !== 2'd0 || sif.RGBStr_o !== 26'd0 || sif.switch_o !== 1'b0) begin miss++; $display("FAIL rstpend: got sel %0d out %h sw %b want 0 0 0", sif.sel_o, sif.RGBStr_o, sif.switch_o); end
    sif.sel_i = 2'd0;
    tick();
    rst = 1'b0;
    wait_sof();
    tick();
    vec++; if (sif.sel_o !== 2'd0 || sif.switch_o !== 1'b0) begin miss++; $display("FAIL rstpend_discard: got sel %0d sw %b want 0 0", sif.sel_o, sif.switch_o); end
  endtask

`ifdef PXS_SCHED_BLANK_EN
  task automatic test_blank();
    logic [25:0] rgb_off = 26'h3FFF000;
    sif.sel_i = 2'd1;
    tick();
    wait_sof();
    tick();
    vec++; if (sif.sel_o !== 2'd1 || sif.RGBStr_o !== (mk(1, 0, 0) & rgb_off)) begin miss++; $display("FAIL blank_first: got sel %0d out %h want 1 %h", sif.sel_o, sif.RGBStr_o, mk(1, 0, 0) & rgb_off); end
    repeat (10) tick();
    vec++; if (sif.RGBStr_o !== (mk(1, prev_x, prev_y) & rgb_off)) begin miss++; $display("FAIL blank_mid: got %h want %h", sif.RGBStr_o, mk(1, prev_x, prev_y) & rgb_off); end
    wait_sof();
    tick();
    vec++; if (sif.RGBStr_o !== mk(1, 0, 0)) begin miss++; $display("FAIL blank_end: got %h want %h", sif.RGBStr_o, mk(1, 0, 0)); end
    sif.sel_i = 2'd2;
    tick();
    wait_sof();
    tick();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    vec++; if (sif.sel_o !== 2'd0 || sif.RGBStr_o !== 26'd0) begin miss++; $display("FAIL blank_rst: got sel %0d out %h want 0 0", sif.sel_o, sif.RGBStr_o); end
    sif.sel_i = 2'd0;
    tick();
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    sif.auto_i  = 1'b0;
    sif.sel_i   = 2'd0;
    sif.next_i  = 1'b0;
    sif.mask_i  = 4'b0000;
    sif.dwell_i = 8'd0;
    drive();
    test_reset();
    test_manual();
    test_sof_coincide();
    test_cancel();
    test_auto();
    test_dwell_zero();
    test_next();
    test_reset_pend();
`ifdef PXS_SCHED_BLANK_EN
    test_blank();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
`default_nettype wire
